// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data-stage and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_rsp_valid;
    logic [DATA_W-1:0] if_rsp_data;
    logic              dm_req_valid;
    logic              dm_req_we;
    logic [ADDR_W-1:0] dm_req_addr;
    logic [DATA_W-1:0] dm_req_wdata;
    logic              dm_req_ready;
    logic              dm_rsp_valid;
    logic [DATA_W-1:0] dm_rsp_rdata;
    logic              mem_req_valid;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_rdata;
    logic              busy;
    logic              protocol_err;

    modport slave (
        input  if_req_valid, if_req_addr, dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata,
               mem_rsp_valid, mem_rsp_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_data, dm_req_ready, dm_rsp_valid, dm_rsp_rdata,
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, busy, protocol_err
    );

    modport master (
        output if_req_valid, if_req_addr, dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata,
               mem_rsp_valid, mem_rsp_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_data, dm_req_ready, dm_rsp_valid, dm_rsp_rdata,
               mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, busy, protocol_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data stage, one transaction
// outstanding, data priority bounded by a fetch starvation counter.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave io_bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

    state_t            r_state, w_next;
    logic [SW-1:0]     r_starve, w_starve_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic              r_req_pulse;
    logic              r_if_rsp_valid, r_dm_rsp_valid;
    logic [DATA_W-1:0] r_if_rsp_data, r_dm_rsp_data;
    logic              r_err;
    logic              w_idle, w_starved, w_dm_win, w_if_win, w_rsp_ok;

    // Readies are gated by rst so every output reads 0 while reset is held.
    assign w_idle    = (r_state == IDLE) && !rst;
    assign w_starved = io_bus.if_req_valid && (r_starve == SW'(STARVE_MAX));
    assign w_dm_win  = w_idle && io_bus.dm_req_valid && !w_starved;
    assign w_if_win  = w_idle && io_bus.if_req_valid && !w_dm_win;
    assign w_rsp_ok  = io_bus.mem_rsp_valid && !r_req_pulse && (r_state != IDLE);

    always_comb begin
        w_next        = r_state;
        w_starve_next = r_starve;
        if (w_dm_win) begin
            w_next = WAIT_D;
            if (io_bus.if_req_valid && (r_starve != SW'(STARVE_MAX)))
                w_starve_next = r_starve + 1'b1;
        end else if (w_if_win) begin
            w_next        = WAIT_I;
            w_starve_next = '0;
        end else if (w_rsp_ok) begin
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_starve       <= '0;
            r_addr         <= '0;
            r_we           <= 1'b0;
            r_wdata        <= '0;
            r_req_pulse    <= 1'b0;
            r_if_rsp_valid <= 1'b0;
            r_dm_rsp_valid <= 1'b0;
            r_if_rsp_data  <= '0;
            r_dm_rsp_data  <= '0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_starve       <= w_starve_next;
            r_req_pulse    <= w_dm_win || w_if_win;
            r_if_rsp_valid <= w_rsp_ok && (r_state == WAIT_I);
            r_dm_rsp_valid <= w_rsp_ok && (r_state == WAIT_D);
            if (w_dm_win) begin
                r_addr  <= io_bus.dm_req_addr;
                r_we    <= io_bus.dm_req_we;
                r_wdata <= io_bus.dm_req_wdata;
            end else if (w_if_win) begin
                r_addr  <= io_bus.if_req_addr;
                r_we    <= 1'b0;
                r_wdata <= '0;
            end
            if (w_rsp_ok && (r_state == WAIT_I))
                r_if_rsp_data <= io_bus.mem_rsp_rdata;
            if (w_rsp_ok && (r_state == WAIT_D))
                r_dm_rsp_data <= io_bus.mem_rsp_rdata;
            // A response with nothing outstanding, or in the request cycle itself, is illegal.
            if (io_bus.mem_rsp_valid && ((r_state == IDLE) || r_req_pulse))
                r_err <= 1'b1;
        end
    end

    assign io_bus.if_req_ready  = w_if_win;
    assign io_bus.dm_req_ready  = w_dm_win;
    assign io_bus.if_rsp_valid  = r_if_rsp_valid;
    assign io_bus.if_rsp_data   = r_if_rsp_data;
    assign io_bus.dm_rsp_valid  = r_dm_rsp_valid;
    assign io_bus.dm_rsp_rdata  = r_dm_rsp_data;
    assign io_bus.mem_req_valid = r_req_pulse;
    assign io_bus.mem_req_we    = r_we;
    assign io_bus.mem_req_addr  = r_addr;
    assign io_bus.mem_req_wdata = r_wdata;
    assign io_bus.busy          = (r_state != IDLE);
    assign io_bus.protocol_err  = r_err;
endmodule
